// File: rtl/barrett_reducer.sv
// -----------------------------------------------------------------------------
// barrett_reducer
//
// Purpose:
//   Four-stage pipelined Barrett modular reduction. It sits between the
//   Karatsuba product stage and the butterfly add/sub logic. It takes the
//   double-width product x = {prod_H, prod_L} and returns x mod q, where q is
//   an odd K-bit NTT modulus (2^(K-1) < q < 2^K) and mu = floor(2^(2K) / q).
//   Flow control is valid/ready with one global advance: when the consumer
//   back-pressures a valid result, every stage freezes together. Empty
//   stages are not collapsed, so latency is always 4 cycles plus one cycle
//   per stall cycle.
//
// Parameters:
//   DATAWIDTH  width of each product half; the product is 2*DATAWIDTH bits
//   QWIDTH     bit length K of the modulus (QWIDTH <= DATAWIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high; clears all state
//   q          modulus; quasi-static while any stage holds valid data
//   mu         floor(2^(2K)/q), QWIDTH+1 bits; quasi-static like q
//   in_valid   prod_L/prod_H carry a product this cycle
//   in_ready   the pipe accepts input this cycle (= global advance)
//   prod_L     low half of the product
//   prod_H     high half of the product
//   out_valid  result carries a valid residue
//   out_ready  the consumer takes the result this cycle
//   result     x mod q in [0, q-1] whenever x < q^2
// -----------------------------------------------------------------------------
module barrett_reducer #(
  parameter int DATAWIDTH = 32,
  parameter int QWIDTH    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [QWIDTH-1:0]    q,
  input  logic [QWIDTH:0]      mu,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] prod_L,
  input  logic [DATAWIDTH-1:0] prod_H,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QWIDTH-1:0]    result
);

  localparam int K   = QWIDTH;
  localparam int XW  = 2 * DATAWIDTH;  // full product width
  localparam int QHW = K + 1;          // width of the quotient estimates q1, q3
  localparam int Q2W = 2 * K + 2;      // width of q1 * mu
  localparam int RW  = K + 2;          // arithmetic is done modulo 2^(K+2)

  // ---------------------------------------------------------------------------
  // Global advance. A stage may only move when the output slot is free or
  // being drained this cycle; every stage shares this single enable.
  // ---------------------------------------------------------------------------
  logic adv;
  logic v1, v2, v3, v4;

  assign adv       = out_ready | ~v4;
  assign in_ready  = adv;
  assign out_valid = v4;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic [XW-1:0]  x_s1;     // S1: full operand
  logic [Q2W-1:0] q2_s2;    // S2: q1 * mu
  logic [RW-1:0]  xlo_s2;   // S2: x mod 2^(K+2)
  logic [RW-1:0]  t_s3;     // S3: (q3 * q) mod 2^(K+2)
  logic [RW-1:0]  xlo_s3;   // S3: x mod 2^(K+2), carried alongside t
  logic [K-1:0]   res_s4;   // S4: fully reduced residue

  // ---------------------------------------------------------------------------
  // Combinational datapath between the registers
  // ---------------------------------------------------------------------------
  logic [QHW-1:0] q1;
  logic [Q2W-1:0] q2;
  logic [QHW-1:0] q3;
  logic [RW-1:0]  t;
  logic [RW-1:0]  r;
  logic [RW-1:0]  r_fix;
  logic [RW-1:0]  q_ext;
  logic [RW-1:0]  two_q;

  // S1 -> S2: first quotient estimate. For x < q^2 < 2^(2K) the shifted value
  // fits in K+1 bits, so the truncation only matters for out-of-range x.
  assign q1 = QHW'(x_s1 >> (K - 1));

  // Both operands are widened to the product width so that no partial
  // product bits are lost before the shift in the next stage.
  assign q2 = Q2W'(q1) * Q2W'(mu);

  // S2 -> S3: second shift yields the quotient estimate, which undershoots
  // the true quotient by at most 2. Only the low K+2 bits of q3*q are needed
  // because the remainder is known to fit in that range.
  assign q3 = QHW'(q2_s2 >> (K + 1));
  assign t  = RW'(q3) * RW'(q);

  // S3 -> S4: remainder estimate in [0, 3q), then at most one subtraction
  // of q or 2q. Wrapping subtraction is intended here.
  assign r     = xlo_s3 - t_s3;
  assign q_ext = RW'(q);
  assign two_q = q_ext << 1;

  always_comb begin
    // NOTE: r_fix gets a default before any branch so every path assigns it;
    // a path that left it unassigned would infer a latch.
    r_fix = r;
    if (r >= two_q) begin
      r_fix = r - two_q;
    end else if (r >= q_ext) begin
      r_fix = r - q_ext;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state. Valid bits shift on every advance so bubbles travel
  // with the data; data registers only load when their upstream stage holds
  // valid data, which keeps result steady across bubbles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset as well as the valid bits because
      // result must read 0 during and after reset, and it keeps X out of
      // the multipliers in simulation.
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      v4     <= 1'b0;
      x_s1   <= '0;
      q2_s2  <= '0;
      xlo_s2 <= '0;
      t_s3   <= '0;
      xlo_s3 <= '0;
      res_s4 <= '0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // cycle's value of its neighbour, which is what makes this a shift.
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;

      if (in_valid) begin
        x_s1 <= {prod_H, prod_L};
      end
      if (v1) begin
        q2_s2  <= q2;
        xlo_s2 <= RW'(x_s1);
      end
      if (v2) begin
        t_s3   <= t;
        xlo_s3 <= xlo_s2;
      end
      if (v3) begin
        res_s4 <= K'(r_fix);
      end
    end
  end

  assign result = res_s4;

  // ---------------------------------------------------------------------------
  // Interface contracts
  // ---------------------------------------------------------------------------

  // A result that is offered but not taken must stay put on the next cycle.
  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(result))
  );

  // q and mu feed stages 2 and 3 directly; changing them with data in
  // flight would corrupt those results.
  a_modulus_quasi_static : assert property (
    @(posedge clk) disable iff (rst)
      (v1 || v2 || v3 || v4) |=> ($stable(q) && $stable(mu))
  );

endmodule

// File: tb/tb_barrett_reducer.sv
// -----------------------------------------------------------------------------
// tb_barrett_reducer
//
// Self-checking bench for barrett_reducer with q = 3329, mu = 5039, K = 12,
// DATAWIDTH = 32. Expected residues come from plain integer x % q; latency and
// ordering expectations come from the 4-cycle, in-order pipeline contract.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_barrett_reducer;

  localparam int DW = 32;
  localparam int QW = 12;
  localparam int Q  = 3329;
  localparam int MU = 5039;

  logic          clk = 1'b0;
  logic          rst;
  logic [QW-1:0] q;
  logic [QW:0]   mu;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] prod_L;
  logic [DW-1:0] prod_H;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  barrett_reducer #(
    .DATAWIDTH(DW),
    .QWIDTH   (QW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .q        (q),
    .mu       (mu),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .prod_L   (prod_L),
    .prod_H   (prod_H),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Reference model: the residue by definition.
  function automatic int ref_mod(input longint unsigned x);
    return int'(x % 64'(Q));
  endfunction

  task automatic set_x(input longint unsigned x);
    {prod_H, prod_L} = x;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, want 0", out_valid);
    end
    n_checks++;
    if (result !== '0) begin
      n_fail++; $display("FAIL reset_result: got %0d, want 0", result);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_out_valid: got %b, want 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    int lat = 0;
    set_x(64'd11075584);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_accept: in_ready %b, want 1", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) lat = i;
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles, want 4", lat);
    end
    n_checks++;
    if (result !== 12'd1) begin
      n_fail++; $display("FAIL single_result: got %0d, want 1", result);
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_boundaries();
    longint unsigned xs[5] = '{64'd0, 64'd3328, 64'd3329, 64'd10000000, 64'd11082240};
    int want[5] = '{0, 3328, 0, 3013, 3328};
    int k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) begin
        set_x(xs[i]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 5) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL boundary_accept_%0d: in_ready %b, want 1", i, in_ready);
        end
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (k >= 5) begin
          n_fail++; $display("FAIL boundary_extra: unexpected result %0d at cycle %0d", result, i);
        end else if (i != k + 4 || result !== QW'(want[k])) begin
          n_fail++;
          $display("FAIL boundary_%0d: got %0d at cycle %0d, want %0d at cycle %0d",
                   k, result, i, want[k], k + 4);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (k != 5) begin
      n_fail++; $display("FAIL boundary_count: got %0d results, want 5", k);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Streams n_ops random operands. out_ready follows 1,0,0,1,0,0,... or is
  // random; every cycle checks in_ready = out_ready | ~out_valid, hold under
  // back-pressure, and in-order residues from the scoreboard.
  task automatic run_traffic(input string tag, input int n_ops, input bit rand_ready,
                             input int p_valid);
    int sent = 0;
    int k = 0;
    int want;
    int budget;
    bit stalled_prev = 1'b0;
    bit fire_in;
    logic [QW-1:0] res_prev = '0;
    longint unsigned x = 0;
    budget = n_ops * 8 + 64;
    exp_q.delete();
    in_valid = 1'b0;
    while ((sent < n_ops || exp_q.size() != 0) && k < budget) begin
      if (!in_valid && sent < n_ops && $urandom_range(0, 99) < p_valid) begin
        x = $urandom_range(0, Q * Q - 1);
        set_x(x);
        in_valid = 1'b1;
      end
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : (k % 3 == 0);
      @(negedge clk);
      n_checks++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        n_fail++;
        $display("FAIL %s_in_ready: got %b, want %b (out_ready %b out_valid %b)",
                 tag, in_ready, out_ready | ~out_valid, out_ready, out_valid);
      end
      if (stalled_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || result !== res_prev) begin
          n_fail++;
          $display("FAIL %s_hold: got valid %b result %0d, want valid 1 result %0d",
                   tag, out_valid, result, res_prev);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s_spurious: result %0d with nothing outstanding", tag, result);
        end else begin
          want = exp_q.pop_front();
          if (result !== QW'(want)) begin
            n_fail++; $display("FAIL %s_result: got %0d, want %0d", tag, result, want);
          end
        end
      end
      fire_in = in_valid && in_ready;
      if (fire_in) begin
        exp_q.push_back(ref_mod(x));
        sent++;
      end
      stalled_prev = (out_valid === 1'b1) && !out_ready;
      res_prev     = result;
      @(posedge clk); #1;
      if (fire_in) in_valid = 1'b0;
      k++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (sent != n_ops || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_complete: sent %0d of %0d, %0d outstanding after %0d cycles",
               tag, sent, n_ops, exp_q.size(), k);
    end
  endtask

  task automatic test_stall();
    run_traffic("stall", 8, 1'b0, 100);
  endtask

  task automatic test_random();
    run_traffic("random", 10000, 1'b1, 70);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full_pipe();
    longint unsigned xs[5];
    int want[5];
    int acc = 0;
    int k = 1;
    for (int i = 0; i < 5; i++) begin
      xs[i]   = $urandom_range(0, Q * Q - 1);
      want[i] = ref_mod(xs[i]);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_x(xs[0]);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) break;
      acc++;
      @(posedge clk); #1;
      if (acc < 5) set_x(xs[acc]);
    end
    n_checks++;
    if (acc != 4) begin
      n_fail++; $display("FAIL full_fill: accepted %0d before in_ready fell, want 4", acc);
    end
    n_checks++;
    if (out_valid !== 1'b1 || result !== QW'(want[0])) begin
      n_fail++; $display("FAIL full_head: got valid %b result %0d, want valid 1 result %0d",
                         out_valid, result, want[0]);
    end
    // Release back-pressure with the fifth operand still pending: one result
    // leaves and one operand enters on the same edge.
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_simultaneous: in_ready %b, want 1", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 10 && k < 5; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_checks++;
        if (result !== QW'(want[k])) begin
          n_fail++; $display("FAIL full_drain_%0d: got %0d, want %0d", k, result, want[k]);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (k != 5) begin
      n_fail++; $display("FAIL full_no_loss: drained %0d of 4 remaining results", k - 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream();
    longint unsigned xs[3];
    int lat = 0;
    xs[0] = 64'd3330;
    xs[1] = $urandom_range(0, Q * Q - 1);
    xs[2] = $urandom_range(0, Q * Q - 1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        set_x(xs[i]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 12'd1) begin
      n_fail++; $display("FAIL midreset_pre: got valid %b result %0d, want valid 1 result 1",
                         out_valid, result);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== '0) begin
      n_fail++; $display("FAIL midreset_async: got valid %b result %0d, want valid 0 result 0",
                         out_valid, result);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_in_ready: got %b, want 1", in_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    set_x(64'd6658);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_accept: in_ready %b out_valid %b, want 1 and 0",
                         in_ready, out_valid);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) lat = i;
    end
    n_checks++;
    if (lat != 4 || result !== '0) begin
      n_fail++; $display("FAIL midreset_first_op: got result %0d after %0d cycles, want 0 after 4",
                         result, lat);
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    q         = QW'(Q);
    mu        = (QW + 1)'(MU);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prod_L    = '0;
    prod_H    = '0;

    test_reset();
    test_single();
    test_boundaries();
    test_stall();
    test_full_pipe();
    test_reset_midstream();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
